// File: rtl/backend_pkg.sv
// Shared constants, packet field positions and FSM state types for the backend hub.
package backend_pkg;

  localparam int NMOD       = 4;
  localparam int DLINES     = 3;
  localparam int PKT_LEN    = 128;
  localparam int CMD_LEN    = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 16;

  localparam logic [3:0] CMD_MARK = 4'hF;
  localparam logic [3:0] BCAST    = 4'hF;
  localparam logic [4:0] HDR      = 5'b11111;

  // Module packet field positions
  localparam int HDR_HI        = 127;
  localparam int HDR_LO        = 123;
  localparam int IS_SINGLE_POS = 122;
  localparam int MOD_ID_HI     = 121;
  localparam int MOD_ID_LO     = 118;
  localparam int IS_CMD_POS    = 115;
  localparam int PAYLOAD_HI    = 31;
  localparam int PAYLOAD_LO    = 0;

  typedef enum logic {DS_IDLE, DS_BUSY} deser_state_t;
  typedef enum logic {SER_IDLE, SER_BUSY} ser_state_t;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  typedef struct packed {
    logic [3:0]         target;
    logic [CMD_LEN-1:0] word;
  } cmd_entry_t;

  // A host target nibble is usable if it names a real module or is the broadcast code.
  function automatic logic target_ok(input logic [3:0] tgt);
    return (tgt == BCAST) || (tgt < 4'(NMOD));
  endfunction

  // One-hot set of serialisers a command goes to.
  function automatic logic [NMOD-1:0] target_mask(input logic [3:0] tgt);
    if (tgt == BCAST) return '1;
    return NMOD'(1) << tgt[1:0];
  endfunction

endpackage

// File: rtl/lane_deser.sv
// Start-framed deserialiser for a group of parallel data lines. An all-high
// start cycle opens a frame; then ceil((LENGTH+1)/LINES) groups follow, highest
// line carrying the MSB of each group. Leading pad bits fall off the top of the
// shift register so data holds exactly the last LENGTH bits received.
module lane_deser import backend_pkg::*; #(
  parameter int LENGTH = PKT_LEN,
  parameter int LINES  = DLINES
) (
  input  logic              sys_clk,
  input  logic              sys_rst_mask,
  input  logic [LINES-1:0]  lines,
  output logic              valid,
  output logic [LENGTH-1:0] data
);

  localparam int NGROUPS = (LENGTH + LINES) / LINES;
  localparam int CW      = $clog2(NGROUPS);
  localparam logic [CW-1:0] LAST = CW'(NGROUPS - 1);

  deser_state_t      state_reg, state_next;
  logic [CW-1:0]     cnt_reg;
  logic [LENGTH-1:0] sh_reg;
  logic              valid_reg;

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_mask) begin
    if (!sys_rst_mask) state_reg <= DS_IDLE;
    else               state_reg <= state_next;
  end

  // Next state: wait for the start pattern, then count groups
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      DS_IDLE: if (lines == '1)      state_next = DS_BUSY;
      DS_BUSY: if (cnt_reg == LAST)  state_next = DS_IDLE;
      default:                       state_next = DS_IDLE;
    endcase
  end

  // Shift groups in and flag the final one
  always_ff @(posedge sys_clk or negedge sys_rst_mask) begin
    if (!sys_rst_mask) begin
      cnt_reg   <= '0;
      sh_reg    <= '0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      if (state_reg == DS_BUSY) begin
        sh_reg  <= {sh_reg[LENGTH-LINES-1:0], lines};
        cnt_reg <= cnt_reg + 1'b1;
        if (cnt_reg == LAST) valid_reg <= 1'b1;
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign valid = valid_reg;
  assign data  = sh_reg;

endmodule

// File: rtl/backend_core.sv
// Backend hub: host bytes -> 32-bit commands -> per-module serial lines, and
// module packets -> response words -> host bytes, plus single-event counters.
module backend_core import backend_pkg::*; (
  input  logic                sys_clk,
  input  logic                sys_rst_mask,
  output logic [NMOD-1:0]     m_clk,
  output logic [NMOD-1:0]     m_ctrl,
  input  logic [NMOD*DLINES-1:0] m_data,
  output logic                user_hs_clk,
  input  logic [7:0]          Q,
  input  logic                nRx,
  input  logic [2:0]          RC,
  output logic                nRF,
  output logic [7:0]          D,
  output logic                nTx,
  output logic [2:0]          TC,
  input  logic [7:0]          nTF,
  output logic [NMOD*CNT_W-1:0] single_cnt
);

  assign m_clk       = {NMOD{sys_clk}};
  assign user_hs_clk = sys_clk;
  assign TC          = 3'b000;

  // Receive channel and the other flow-control channels are not used
  logic in_unused;
  assign in_unused = ^{RC, nTF[7:1]};

  // ---------------- host byte assembler ----------------
  logic [1:0]         byte_cnt_reg;
  logic [23:0]        asm_reg;
  logic [CMD_LEN-1:0] rx_word;
  logic               word_done;

  assign rx_word   = {asm_reg, Q};
  assign word_done = !nRx && (byte_cnt_reg == 2'd3);

  // Collect bytes MSB first; a gap in nRx throws away any partial word
  always_ff @(posedge sys_clk or negedge sys_rst_mask) begin
    if (!sys_rst_mask) begin
      byte_cnt_reg <= '0;
      asm_reg      <= '0;
    end else if (!nRx) begin
      asm_reg      <= {asm_reg[15:0], Q};
      byte_cnt_reg <= byte_cnt_reg + 1'b1;
    end else begin
      byte_cnt_reg <= '0;
    end
  end

  // ---------------- command FIFO ----------------
  cmd_entry_t      fifo_mem [FIFO_DEPTH];
  logic [1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [2:0]      count_reg;
  logic            fifo_full, fifo_empty, push, pop;
  cmd_entry_t      head;
  logic [NMOD-1:0] head_mask, ser_busy;
  logic            ld_valid_reg;
  logic [NMOD-1:0] ld_mask_reg;
  logic [CMD_LEN-1:0] ld_word_reg;

  assign fifo_full  = (count_reg == 3'(FIFO_DEPTH));
  assign fifo_empty = (count_reg == 3'd0);
  assign push = word_done && (rx_word[31:28] == CMD_MARK) &&
                target_ok(rx_word[27:24]) && !fifo_full;
  assign head      = fifo_mem[rd_ptr_reg];
  assign head_mask = target_mask(head.target);
  // A broadcast waits until every serialiser is free; one pop in flight at a time
  assign pop = !fifo_empty && !ld_valid_reg && ((head_mask & ser_busy) == '0);
  assign nRF = !fifo_full;

  // Storage write
  always_ff @(posedge sys_clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= '{target: rx_word[27:24], word: rx_word};
  end

  // Pointers, occupancy and the load stage feeding the serialisers
  always_ff @(posedge sys_clk or negedge sys_rst_mask) begin
    if (!sys_rst_mask) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      ld_valid_reg <= 1'b0;
      ld_mask_reg  <= '0;
      ld_word_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      ld_valid_reg <= pop;
      if (pop) begin
        ld_mask_reg <= head_mask;
        ld_word_reg <= head.word;
      end
    end
  end

  // ---------------- per-module lanes ----------------
  logic [NMOD-1:0]    resp_full, tx_clear;
  logic [CMD_LEN-1:0] resp_word [NMOD];
  logic               tx_done;
  logic [1:0]         tx_sel_reg;

  for (genvar gi = 0; gi < NMOD; gi++) begin : g_lane
    ser_state_t         state_reg, state_next;
    logic [CMD_LEN-1:0] sh_reg;
    logic [5:0]         cnt_reg;
    logic               line_reg, load;
    logic               pkt_valid, hdr_ok, pkt_unused;
    logic [PKT_LEN-1:0] pkt_data;
    logic [CNT_W-1:0]   single_reg;
    logic               full_reg;
    logic [CMD_LEN-1:0] word_reg;

    assign load        = ld_valid_reg && ld_mask_reg[gi];
    assign ser_busy[gi] = (state_reg == SER_BUSY);
    assign m_ctrl[gi]  = line_reg;

    // Serialiser state register
    always_ff @(posedge sys_clk or negedge sys_rst_mask) begin
      if (!sys_rst_mask) state_reg <= SER_IDLE;
      else               state_reg <= state_next;
    end

    // Serialiser next state: busy for start bit plus 32 data bits
    always_comb begin
      state_next = state_reg;
      case (state_reg)
        SER_IDLE: if (load)             state_next = SER_BUSY;
        SER_BUSY: if (cnt_reg == 6'd32) state_next = SER_IDLE;
        default:                        state_next = SER_IDLE;
      endcase
    end

    // Drive start bit on load, then shift the word out MSB first, then low
    always_ff @(posedge sys_clk or negedge sys_rst_mask) begin
      if (!sys_rst_mask) begin
        line_reg <= 1'b0;
        sh_reg   <= '0;
        cnt_reg  <= '0;
      end else if (state_reg == SER_IDLE) begin
        line_reg <= load;
        if (load) begin
          sh_reg  <= ld_word_reg;
          cnt_reg <= '0;
        end
      end else if (cnt_reg == 6'd32) begin
        line_reg <= 1'b0;
      end else begin
        line_reg <= sh_reg[CMD_LEN-1];
        sh_reg   <= {sh_reg[CMD_LEN-2:0], 1'b0};
        cnt_reg  <= cnt_reg + 1'b1;
      end
    end

    lane_deser #(.LENGTH(PKT_LEN), .LINES(DLINES)) u_deser (
      .sys_clk      (sys_clk),
      .sys_rst_mask (sys_rst_mask),
      .lines        (m_data[gi*DLINES +: DLINES]),
      .valid        (pkt_valid),
      .data         (pkt_data)
    );

    assign hdr_ok = (pkt_data[HDR_HI:HDR_LO] == HDR);
    // Module id and reserved bits are carried but routing uses the arrival slot
    assign pkt_unused = ^{pkt_data[MOD_ID_HI:MOD_ID_LO], pkt_data[MOD_ID_LO-1:IS_CMD_POS+1],
                          pkt_data[IS_CMD_POS-1:PAYLOAD_HI+1]};

    // Count singles; hold one pending response until the host side drains it
    always_ff @(posedge sys_clk or negedge sys_rst_mask) begin
      if (!sys_rst_mask) begin
        single_reg <= '0;
        full_reg   <= 1'b0;
        word_reg   <= '0;
      end else begin
        if (tx_clear[gi]) full_reg <= 1'b0;
        if (pkt_valid && hdr_ok) begin
          if (pkt_data[IS_SINGLE_POS]) begin
            single_reg <= single_reg + 1'b1;
          end else if (pkt_data[IS_CMD_POS] && !full_reg) begin
            word_reg <= pkt_data[PAYLOAD_HI:PAYLOAD_LO];
            full_reg <= 1'b1;
          end
        end
      end
    end

    assign resp_full[gi] = full_reg;
    assign resp_word[gi] = word_reg;
    assign tx_clear[gi]  = tx_done && (tx_sel_reg == 2'(gi));
    assign single_cnt[gi*CNT_W +: CNT_W] = single_reg;
  end

  // ---------------- host TX arbiter ----------------
  tx_state_t          tx_state_reg, tx_state_next;
  logic [1:0]         rr_ptr_reg, tx_byte_reg, grant_idx;
  logic               grant_valid, tx_start;
  logic [CMD_LEN-1:0] tx_word_reg;
  logic [7:0]         d_reg;
  logic               ntx_reg;

  // Round-robin pick of the first full response at or after the pointer
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = rr_ptr_reg;
    for (int i = 0; i < NMOD; i++) begin
      if (!grant_valid && resp_full[rr_ptr_reg + 2'(i)]) begin
        grant_valid = 1'b1;
        grant_idx   = rr_ptr_reg + 2'(i);
      end
    end
  end

  assign tx_start = (tx_state_reg == TX_IDLE) && nTF[0] && grant_valid;
  assign tx_done  = (tx_state_reg == TX_SEND) && (tx_byte_reg == 2'd0);

  // TX state register
  always_ff @(posedge sys_clk or negedge sys_rst_mask) begin
    if (!sys_rst_mask) tx_state_reg <= TX_IDLE;
    else               tx_state_reg <= tx_state_next;
  end

  // TX next state: flow control only gates the start of a word
  always_comb begin
    tx_state_next = tx_state_reg;
    case (tx_state_reg)
      TX_IDLE: if (tx_start) tx_state_next = TX_SEND;
      TX_SEND: if (tx_done)  tx_state_next = TX_IDLE;
      default:               tx_state_next = TX_IDLE;
    endcase
  end

  // Emit four bytes MSB first with nTx low, then advance the pointer
  always_ff @(posedge sys_clk or negedge sys_rst_mask) begin
    if (!sys_rst_mask) begin
      rr_ptr_reg  <= '0;
      tx_sel_reg  <= '0;
      tx_byte_reg <= '0;
      tx_word_reg <= '0;
      d_reg       <= '0;
      ntx_reg     <= 1'b1;
    end else if (tx_start) begin
      tx_sel_reg  <= grant_idx;
      tx_word_reg <= resp_word[grant_idx];
      d_reg       <= resp_word[grant_idx][31:24];
      ntx_reg     <= 1'b0;
      tx_byte_reg <= 2'd1;
    end else if (tx_done) begin
      d_reg      <= '0;
      ntx_reg    <= 1'b1;
      rr_ptr_reg <= tx_sel_reg + 1'b1;
    end else if (tx_state_reg == TX_SEND) begin
      d_reg       <= tx_word_reg[23:16];
      tx_word_reg <= {tx_word_reg[23:0], 8'h00};
      tx_byte_reg <= tx_byte_reg + 1'b1;
    end
  end

  assign D   = d_reg;
  assign nTx = ntx_reg;

endmodule

// File: tb/tb_backend_core.sv
// Directed bench for backend_core: host command framing, module packet
// handling, host byte returns, flow control, arbitration and reset abort.
module tb_backend_core;

  logic        sys_clk = 1'b0;
  logic        sys_rst_mask = 1'b0;
  logic [3:0]  m_clk, m_ctrl;
  logic [11:0] m_data = '0;
  logic        user_hs_clk;
  logic [7:0]  Q = '0;
  logic        nRx = 1'b1;
  logic [2:0]  RC = '0;
  logic        nRF;
  logic [7:0]  D;
  logic        nTx;
  logic [2:0]  TC;
  logic [7:0]  nTF = 8'hFF;
  logic [63:0] single_cnt;

  backend_core dut (
    .sys_clk(sys_clk), .sys_rst_mask(sys_rst_mask), .m_clk(m_clk), .m_ctrl(m_ctrl),
    .m_data(m_data), .user_hs_clk(user_hs_clk), .Q(Q), .nRx(nRx), .RC(RC), .nRF(nRF),
    .D(D), .nTx(nTx), .TC(TC), .nTF(nTF), .single_cnt(single_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int     n_checks = 0;
  int     n_errors = 0;
  longint cyc = 0;

  typedef struct {int line; logic [31:0] word; longint at;} frame_t;
  typedef struct {logic [7:0] b; longint at;} txb_t;
  frame_t frames[$];
  txb_t   tx_bytes[$];
  int          mon_cnt [4];
  logic [31:0] mon_sh  [4];
  longint      mon_at  [4];

  // Line monitor: decodes command frames on m_ctrl and records host TX bytes
  initial begin
    for (int k = 0; k < 4; k++) mon_cnt[k] = 0;
    forever begin
      @(posedge sys_clk);
      cyc++;
      #1;
      if (!sys_rst_mask) begin
        for (int k = 0; k < 4; k++) mon_cnt[k] = 0;
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (mon_cnt[k] == 0) begin
            if (m_ctrl[k]) begin
              mon_cnt[k] = 1;
              mon_at[k]  = cyc;
            end
          end else begin
            mon_sh[k] = {mon_sh[k][30:0], m_ctrl[k]};
            mon_cnt[k]++;
            if (mon_cnt[k] == 33) begin
              frames.push_back('{k, mon_sh[k], mon_at[k]});
              mon_cnt[k] = 0;
            end
          end
        end
        if (!nTx) tx_bytes.push_back('{D, cyc});
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      Q   = w[31-8*i -: 8];
      nRx = 1'b0;
      tick(1);
    end
    nRx = 1'b1;
    Q   = '0;
  endtask

  function automatic logic [127:0] make_pkt(input logic single, input logic [3:0] id,
                                           input logic cmd, input logic [31:0] payload,
                                           input logic [4:0] hdr);
    logic [127:0] p;
    p = '0;
    p[127:123] = hdr;
    p[122]     = single;
    p[121:118] = id;
    p[115]     = cmd;
    p[31:0]    = payload;
    return p;
  endfunction

  task automatic send_pkt(input int k, input logic [127:0] pkt);
    logic [128:0] fr;
    fr = {1'b0, pkt};
    m_data[3*k +: 3] = 3'b111;
    tick(1);
    for (int g = 0; g < 43; g++) begin
      m_data[3*k +: 3] = fr[128-3*g -: 3];
      tick(1);
    end
    m_data[3*k +: 3] = 3'b000;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t = 0;
    while (frames.size() < n && t < budget) begin
      tick(1);
      t++;
    end
  endtask

  task automatic wait_tx(input int n, input int budget);
    int t = 0;
    while (tx_bytes.size() < n && t < budget) begin
      tick(1);
      t++;
    end
  endtask

  task automatic expect_frame(input string tag, input int line, input logic [31:0] word,
                              output longint at);
    frame_t f;
    at = -1;
    check({tag, "_avail"}, 64'(frames.size() > 0), 64'd1);
    if (frames.size() > 0) begin
      f = frames.pop_front();
      check({tag, "_line"}, 64'(f.line), 64'(line));
      check({tag, "_word"}, 64'(f.word), 64'(word));
      at = f.at;
    end
  endtask

  task automatic expect_tx(input string tag, input logic [31:0] word);
    check({tag, "_avail"}, 64'(tx_bytes.size() >= 4), 64'd1);
    if (tx_bytes.size() >= 4) begin
      for (int i = 0; i < 4; i++)
        check($sformatf("%s_b%0d", tag, i), 64'(tx_bytes[i].b), 64'(word[31-8*i -: 8]));
      check({tag, "_span"}, 64'(tx_bytes[3].at - tx_bytes[0].at), 64'd3);
      for (int i = 0; i < 4; i++) void'(tx_bytes.pop_front());
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    longint t0, at0, at;
    // Reset values
    sys_rst_mask = 1'b0;
    tick(3);
    check("rst_m_ctrl", 64'(m_ctrl), 64'h0);
    check("rst_D", 64'(D), 64'h0);
    check("rst_nTx", 64'(nTx), 64'h1);
    check("rst_nRF", 64'(nRF), 64'h1);
    check("rst_TC", 64'(TC), 64'h0);
    check("rst_single", single_cnt, 64'h0);
    sys_rst_mask = 1'b1;
    tick(2);

    // Unicast to module 0, with start-bit latency
    send_word(32'hF0800000, 4);
    t0 = cyc;
    wait_frames(1, 80);
    expect_frame("uni0", 0, 32'hF0800000, at);
    check("uni0_latency", 64'(at - t0), 64'd2);
    tick(10);
    check("uni0_others_quiet", 64'(frames.size()), 64'd0);

    send_word(32'hF06404FF, 4);
    wait_frames(1, 80);
    expect_frame("uni1", 0, 32'hF06404FF, at);

    // Bad mark and bad target are dropped
    send_word(32'hA0000000, 4);
    tick(60);
    check("badmark_noframe", 64'(frames.size()), 64'd0);
    send_word(32'hF7123456, 4);
    tick(60);
    check("badtgt_noframe", 64'(frames.size()), 64'd0);

    // Broadcast: all lines start together
    send_word(32'hFF123456, 4);
    wait_frames(4, 80);
    expect_frame("bc_l0", 0, 32'hFF123456, at0);
    for (int k = 1; k < 4; k++) begin
      expect_frame($sformatf("bc_l%0d", k), k, 32'hFF123456, at);
      check($sformatf("bc_l%0d_sync", k), 64'(at - at0), 64'd0);
    end

    // FIFO fill: first word goes straight to the serialiser, next four fill the queue
    for (int w = 1; w <= 6; w++) begin
      for (int i = 0; i < 4; i++) begin
        Q   = (i == 0) ? 8'hF1 : ((i == 3) ? 8'(w) : 8'h00);
        nRx = 1'b0;
        tick(1);
      end
      if (w == 4) check("fifo3_nRF_high", 64'(nRF), 64'h1);
      if (w == 5) check("fifo4_nRF_low", 64'(nRF), 64'h0);
    end
    nRx = 1'b1;
    wait_frames(5, 300);
    for (int w = 1; w <= 5; w++)
      expect_frame($sformatf("fifo_w%0d", w), 1, 32'hF1000000 | 32'(w), at);
    tick(60);
    check("fifo_w6_dropped", 64'(frames.size()), 64'd0);
    check("fifo_drained_nRF", 64'(nRF), 64'h1);

    // Partial burst discarded
    send_word(32'hF0801200, 3);
    tick(3);
    send_word(32'hF0000001, 4);
    wait_frames(1, 80);
    expect_frame("partial", 0, 32'hF0000001, at);
    tick(40);
    check("partial_noextra", 64'(frames.size()), 64'd0);

    // Command response from module 0
    send_pkt(0, make_pkt(1'b0, 4'd0, 1'b1, 32'hDEADBEEF, 5'b11111));
    wait_tx(4, 40);
    expect_tx("resp0", 32'hDEADBEEF);
    tick(20);
    check("resp0_exactly4", 64'(tx_bytes.size()), 64'd0);

    // Flow control holds off the word
    nTF = 8'hFE;
    send_pkt(0, make_pkt(1'b0, 4'd0, 1'b1, 32'h0123ABCD, 5'b11111));
    tick(40);
    check("ntf_hold", 64'(tx_bytes.size()), 64'd0);
    nTF = 8'hFF;
    wait_tx(4, 40);
    expect_tx("ntf_release", 32'h0123ABCD);

    // Second response while the register is full is dropped
    nTF = 8'hFE;
    send_pkt(0, make_pkt(1'b0, 4'd0, 1'b1, 32'hA1A2A3A4, 5'b11111));
    send_pkt(0, make_pkt(1'b0, 4'd0, 1'b1, 32'hB1B2B3B4, 5'b11111));
    tick(5);
    nTF = 8'hFF;
    wait_tx(4, 40);
    expect_tx("full_keep_first", 32'hA1A2A3A4);
    tick(40);
    check("full_second_dropped", 64'(tx_bytes.size()), 64'd0);

    // Single on module 2 (cmd bit also set: single wins)
    send_pkt(2, make_pkt(1'b1, 4'd2, 1'b1, 32'h55555555, 5'b11111));
    tick(20);
    check("single_cnt2", single_cnt, 64'h0000_0001_0000_0000);
    check("single_no_tx", 64'(tx_bytes.size()), 64'd0);

    // Bad header is ignored
    send_pkt(1, make_pkt(1'b0, 4'd1, 1'b1, 32'h77777777, 5'b11110));
    tick(20);
    check("badhdr_no_tx", 64'(tx_bytes.size()), 64'd0);
    check("badhdr_single", single_cnt, 64'h0000_0001_0000_0000);

    // Round robin: pointer sits at 1, so module 3 beats module 0
    fork
      send_pkt(0, make_pkt(1'b0, 4'd0, 1'b1, 32'hC0C1C2C3, 5'b11111));
      send_pkt(3, make_pkt(1'b0, 4'd3, 1'b1, 32'hD0D1D2D3, 5'b11111));
    join
    wait_tx(8, 60);
    expect_tx("rr_first_m3", 32'hD0D1D2D3);
    expect_tx("rr_second_m0", 32'hC0C1C2C3);

    // Reset in the middle of a command frame
    send_word(32'hF3AA5501, 4);
    tick(10);
    #2;
    sys_rst_mask = 1'b0;
    #1;
    check("midrst_m_ctrl", 64'(m_ctrl), 64'h0);
    check("midrst_nTx", 64'(nTx), 64'h1);
    check("midrst_D", 64'(D), 64'h0);
    check("midrst_nRF", 64'(nRF), 64'h1);
    check("midrst_single", single_cnt, 64'h0);
    tick(2);
    sys_rst_mask = 1'b1;
    tick(60);
    check("midrst_noframe", 64'(frames.size()), 64'd0);
    check("midrst_no_tx", 64'(tx_bytes.size()), 64'd0);

    // Recovery after reset
    send_word(32'hF0000002, 4);
    wait_frames(1, 80);
    expect_frame("recover", 0, 32'hF0000002, at);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
